// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS fetch path: reset vector, instruction width,
// the buffered fetch entry and the word-alignment helper.
package mips_pkg;

    localparam logic [31:0] RESET_PC  = 32'h0000_3000;
    localparam int          INSTR_W   = 32;
    localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0000;

    typedef struct packed {
        logic [31:0]        pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

    function automatic logic [31:0] word_addr(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/ifetch_fifo.sv
// Instruction buffer between memory responses and decode: a synchronous FIFO
// of {pc, instr} entries where clear overrides push and pop.
import mips_pkg::*;

module ifetch_fifo #(
    parameter int DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   clear,
    input  fetch_entry_t           wdata,
    output fetch_entry_t           rdata,
    output logic [$clog2(DEPTH):0] count,
    output logic                   empty,
    output logic                   full
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    fetch_entry_t   mem_r [DEPTH];
    logic [AW-1:0]  wr_ptr_r;
    logic [AW-1:0]  rd_ptr_r;
    logic [CW-1:0]  count_r;
    logic           push_ok_s;
    logic           pop_ok_s;

    assign empty     = (count_r == {CW{1'b0}});
    assign full      = (count_r == CW'(DEPTH));
    assign pop_ok_s  = pop && !empty;
    // A push into a full buffer is only taken when the head leaves the same cycle.
    assign push_ok_s = push && (!full || pop_ok_s);
    assign rdata     = mem_r[rd_ptr_r];
    assign count     = count_r;

    // Storage, pointers and occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '{pc: 32'h0000_0000, instr: NOP_INSTR};
            end
        end else if (clear) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (push_ok_s) begin
                mem_r[wr_ptr_r] <= wdata;
                wr_ptr_r        <= wr_ptr_r + AW'(1);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/ifetch_unit.sv
// Instruction-fetch stage: issues one read at a time to instruction memory,
// buffers returned words with their PCs and hands them to decode.
import mips_pkg::*;

module ifetch_unit #(
    parameter int DEPTH = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [31:0]        pc,
    output logic               pc_en,
    input  logic               flush,
    output logic               imem_req,
    output logic [31:0]        imem_addr,
    input  logic               imem_gnt,
    input  logic               imem_rvalid,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               id_valid,
    output logic [INSTR_W-1:0] id_instr,
    output logic [31:0]        id_pc,
    input  logic               id_ready
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic           outstanding_r;
    logic           drop_r;
    logic [31:0]    req_pc_r;
    logic           req_s;
    logic           grant_s;
    logic           deq_s;
    logic           credit_s;
    logic           resp_s;
    logic           push_s;
    logic           empty_s;
    logic           full_s;
    logic [CW-1:0]  count_s;
    logic [CW-1:0]  occupancy_s;
    fetch_entry_t   head_s;
    fetch_entry_t   wdata_s;

    assign deq_s       = !empty_s && id_ready;
    // The in-flight read already owns a slot, so it counts against the buffer.
    assign occupancy_s = count_s + CW'(outstanding_r);
    assign credit_s    = (!full_s && (occupancy_s < CW'(DEPTH))) || deq_s;

    // Request only when no read is pending (or it completes now) and a slot is free.
    always_comb begin
        req_s = 1'b0;
        if (!rst && !flush && (!outstanding_r || imem_rvalid) && credit_s) begin
            req_s = 1'b1;
        end else begin
            req_s = 1'b0;
        end
    end

    assign grant_s   = req_s && imem_gnt;
    assign resp_s    = imem_rvalid && outstanding_r;
    assign push_s    = resp_s && !drop_r && !flush;
    assign wdata_s   = '{pc: req_pc_r, instr: imem_rdata};

    assign imem_req  = req_s;
    assign imem_addr = word_addr(pc);
    assign pc_en     = !rst && (flush || grant_s);

    assign id_valid  = !empty_s;
    assign id_instr  = head_s.instr;
    assign id_pc     = head_s.pc;

    // Outstanding-read and late-response drop tracking.
    always_ff @(posedge clk) begin
        if (rst) begin
            outstanding_r <= 1'b0;
            drop_r        <= 1'b0;
            req_pc_r      <= RESET_PC;
        end else begin
            if (grant_s) begin
                outstanding_r <= 1'b1;
                req_pc_r      <= pc;
            end else if (resp_s) begin
                outstanding_r <= 1'b0;
            end
            if (flush) begin
                drop_r <= outstanding_r && !imem_rvalid;
            end else if (resp_s) begin
                drop_r <= 1'b0;
            end
        end
    end

    ifetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_s),
        .pop   (deq_s),
        .clear (flush),
        .wdata (wdata_s),
        .rdata (head_s),
        .count (count_s),
        .empty (empty_s),
        .full  (full_s)
    );

endmodule

// File: tb/tb_ifetch_unit.sv
// Bench for ifetch_unit: directed cycle table, hand-written flush/reset
// sequences, then randomized traffic against a queue-based reference model.
module tb_ifetch_unit;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc;
    logic        pc_en;
    logic        flush;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        id_valid;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic        id_ready;

    int total = 0;
    int bad   = 0;

    ifetch_unit #(.DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .pc          (pc),
        .pc_en       (pc_en),
        .flush       (flush),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .id_valid    (id_valid),
        .id_instr    (id_instr),
        .id_pc       (id_pc),
        .id_ready    (id_ready)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        rst;
        logic        flush;
        logic        gnt;
        logic        rvalid;
        logic        ready;
        logic [31:0] pc;
        logic [31:0] rdata;
        logic        e_req;
        logic        e_pcen;
        logic        e_valid;
        logic [31:0] e_id_pc;
    } vec_t;

    vec_t vt [19];

    // reference model state
    logic [63:0] mq [$];
    bit          m_out;
    bit          m_drop;
    logic [31:0] m_req_pc;
    bit          pend_v;
    int          pend_cnt;
    logic [31:0] pend_data;
    logic        e_req;
    logic        e_pcen;
    logic        e_valid;
    logic        deq;
    logic        grant;
    logic        resp;
    logic [31:0] pc_next;

    function automatic logic [31:0] ins(input logic [31:0] a);
        return a ^ 32'h1234_0000;
    endfunction

    function automatic vec_t mk(input logic r, input logic f, input logic g,
                                input logic rv, input logic rd,
                                input logic [31:0] p, input logic [31:0] d,
                                input logic er, input logic ep, input logic ev,
                                input logic [31:0] eid);
        vec_t v;
        v = '{r, f, g, rv, rd, p, d, er, ep, ev, eid};
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drv(input logic r, input logic f, input logic g, input logic rv,
                       input logic rd, input logic [31:0] p, input logic [31:0] d);
        rst = r; flush = f; imem_gnt = g; imem_rvalid = rv;
        id_ready = rd; pc = p; imem_rdata = d;
    endtask

    task automatic step(input string tag, input logic er, input logic ep, input logic ev,
                        input bit cpc, input logic [31:0] eid,
                        input bit ci, input logic [31:0] ei);
        @(negedge clk);
        chk({tag, "/req"}, {31'b0, imem_req}, {31'b0, er});
        chk({tag, "/pc_en"}, {31'b0, pc_en}, {31'b0, ep});
        chk({tag, "/valid"}, {31'b0, id_valid}, {31'b0, ev});
        chk({tag, "/addr"}, imem_addr, pc & 32'hFFFF_FFFC);
        if (cpc) chk({tag, "/id_pc"}, id_pc, eid);
        if (ci)  chk({tag, "/id_instr"}, id_instr, ei);
        @(posedge clk);
        #1;
    endtask

    initial begin
        // reset, streaming, backpressure, slow memory, flush with in-flight read
        vt[0]  = mk(1'b1,1'b0,1'b1,1'b1,1'b1,32'h3000,32'hAAAA_0000, 1'b0,1'b0,1'b0,32'h0);
        vt[1]  = mk(1'b1,1'b0,1'b1,1'b1,1'b1,32'h3000,32'hAAAA_0000, 1'b0,1'b0,1'b0,32'h0);
        vt[2]  = mk(1'b0,1'b0,1'b1,1'b0,1'b1,32'h3000,32'h0,         1'b1,1'b1,1'b0,32'h0);
        vt[3]  = mk(1'b0,1'b0,1'b1,1'b1,1'b1,32'h3004,ins(32'h3000), 1'b1,1'b1,1'b0,32'h0);
        vt[4]  = mk(1'b0,1'b0,1'b1,1'b1,1'b1,32'h3008,ins(32'h3004), 1'b1,1'b1,1'b1,32'h3000);
        vt[5]  = mk(1'b0,1'b0,1'b1,1'b1,1'b1,32'h300C,ins(32'h3008), 1'b1,1'b1,1'b1,32'h3004);
        vt[6]  = mk(1'b0,1'b0,1'b1,1'b1,1'b0,32'h3010,ins(32'h300C), 1'b0,1'b0,1'b1,32'h3008);
        vt[7]  = mk(1'b0,1'b0,1'b1,1'b0,1'b0,32'h3010,32'h0,         1'b0,1'b0,1'b1,32'h3008);
        vt[8]  = mk(1'b0,1'b0,1'b1,1'b0,1'b1,32'h3010,32'h0,         1'b1,1'b1,1'b1,32'h3008);
        vt[9]  = mk(1'b0,1'b0,1'b1,1'b1,1'b0,32'h3014,ins(32'h3010), 1'b0,1'b0,1'b1,32'h300C);
        vt[10] = mk(1'b0,1'b0,1'b1,1'b0,1'b1,32'h3014,32'h0,         1'b1,1'b1,1'b1,32'h300C);
        vt[11] = mk(1'b0,1'b0,1'b1,1'b0,1'b1,32'h3018,32'h0,         1'b0,1'b0,1'b1,32'h3010);
        vt[12] = mk(1'b0,1'b0,1'b1,1'b0,1'b1,32'h3018,32'h0,         1'b0,1'b0,1'b0,32'h0);
        vt[13] = mk(1'b0,1'b0,1'b1,1'b1,1'b1,32'h3018,ins(32'h3014), 1'b1,1'b1,1'b0,32'h0);
        vt[14] = mk(1'b0,1'b1,1'b1,1'b0,1'b0,32'h3018,32'h0,         1'b0,1'b1,1'b1,32'h3014);
        vt[15] = mk(1'b0,1'b0,1'b1,1'b0,1'b1,32'h3100,32'h0,         1'b0,1'b0,1'b0,32'h0);
        vt[16] = mk(1'b0,1'b0,1'b1,1'b1,1'b1,32'h3100,32'hDEAD_0018, 1'b1,1'b1,1'b0,32'h0);
        vt[17] = mk(1'b0,1'b0,1'b0,1'b1,1'b1,32'h3104,ins(32'h3100), 1'b1,1'b0,1'b0,32'h0);
        vt[18] = mk(1'b0,1'b0,1'b0,1'b0,1'b0,32'h3104,32'h0,         1'b1,1'b0,1'b1,32'h3100);

        for (int i = 0; i < 19; i++) begin
            drv(vt[i].rst, vt[i].flush, vt[i].gnt, vt[i].rvalid, vt[i].ready, vt[i].pc, vt[i].rdata);
            step($sformatf("tbl%0d", i), vt[i].e_req, vt[i].e_pcen, vt[i].e_valid,
                 vt[i].e_valid || vt[i].rst, vt[i].e_id_pc, vt[i].rst, 32'h0);
        end

        // flush coinciding with rvalid and deq: head consumed, data dropped, nothing left pending
        drv(1'b0,1'b0,1'b1,1'b0,1'b0,32'h3104,32'h0);
        step("fA1", 1'b1,1'b1,1'b1, 1'b1,32'h3100, 1'b1,ins(32'h3100));
        drv(1'b0,1'b1,1'b1,1'b1,1'b1,32'h3108,32'hDEAD_0001);
        step("fA2", 1'b0,1'b1,1'b1, 1'b1,32'h3100, 1'b0,32'h0);
        drv(1'b0,1'b0,1'b1,1'b0,1'b1,32'h3200,32'h0);
        step("fA3", 1'b1,1'b1,1'b0, 1'b0,32'h0, 1'b0,32'h0);
        drv(1'b0,1'b0,1'b0,1'b1,1'b1,32'h3204,32'h0BAD_3200);
        step("fA4", 1'b1,1'b0,1'b0, 1'b0,32'h0, 1'b0,32'h0);
        drv(1'b0,1'b0,1'b0,1'b0,1'b0,32'h3204,32'h0);
        step("fA5", 1'b1,1'b0,1'b1, 1'b1,32'h3200, 1'b1,32'h0BAD_3200);

        // reset abandons an in-flight read; its late response is ignored
        drv(1'b0,1'b0,1'b1,1'b0,1'b1,32'h3204,32'h0);
        step("rB1", 1'b1,1'b1,1'b1, 1'b1,32'h3200, 1'b0,32'h0);
        drv(1'b1,1'b0,1'b1,1'b0,1'b1,32'h3208,32'h0);
        step("rB2", 1'b0,1'b0,1'b0, 1'b0,32'h0, 1'b0,32'h0);
        drv(1'b0,1'b0,1'b0,1'b1,1'b1,32'h3208,32'hBAD0_BAD0);
        step("rB3", 1'b1,1'b0,1'b0, 1'b0,32'h0, 1'b0,32'h0);
        drv(1'b0,1'b0,1'b0,1'b0,1'b0,32'h3208,32'h0);
        step("rB4", 1'b1,1'b0,1'b0, 1'b0,32'h0, 1'b0,32'h0);

        // randomized traffic: bench acts as PC register and memory
        mq.delete();
        m_out = 1'b0; m_drop = 1'b0; m_req_pc = 32'h0;
        pend_v = 1'b0; pend_cnt = 0; pend_data = 32'h0;
        pc = 32'h0000_3000;
        for (int c = 0; c < 3000; c++) begin
            rst         = (c < 2) || ($urandom_range(0, 99) == 0);
            flush       = ($urandom_range(0, 99) < 7);
            id_ready    = ($urandom_range(0, 99) < 70);
            imem_gnt    = ($urandom_range(0, 99) < 80);
            imem_rvalid = 1'b0;
            imem_rdata  = $urandom;
            if (pend_v) begin
                pend_cnt--;
                if (pend_cnt == 0) begin
                    imem_rvalid = 1'b1;
                    imem_rdata  = pend_data;
                    pend_v      = 1'b0;
                end
            end else if ($urandom_range(0, 99) < 4) begin
                imem_rvalid = 1'b1;
            end

            @(negedge clk);
            e_valid = (mq.size() != 0);
            deq     = e_valid && id_ready;
            e_req   = !rst && !flush && (!m_out || imem_rvalid) &&
                      (((mq.size() + int'(m_out)) < DEPTH) || deq);
            grant   = e_req && imem_gnt;
            e_pcen  = !rst && (flush || grant);
            chk("rnd/req", {31'b0, imem_req}, {31'b0, e_req});
            chk("rnd/pc_en", {31'b0, pc_en}, {31'b0, e_pcen});
            chk("rnd/valid", {31'b0, id_valid}, {31'b0, e_valid});
            chk("rnd/addr", imem_addr, pc & 32'hFFFF_FFFC);
            if (e_valid) begin
                chk("rnd/id_pc", id_pc, mq[0][63:32]);
                chk("rnd/id_instr", id_instr, mq[0][31:0]);
            end

            if (rst) begin
                mq.delete();
                m_out  = 1'b0;
                m_drop = 1'b0;
            end else begin
                resp = imem_rvalid && m_out;
                if (deq) void'(mq.pop_front());
                if (resp) begin
                    if (!m_drop && !flush) mq.push_back({m_req_pc, imem_rdata});
                    m_drop = 1'b0;
                    m_out  = 1'b0;
                end
                if (flush) begin
                    mq.delete();
                    if (m_out && !imem_rvalid) m_drop = 1'b1;
                end
                if (grant) begin
                    m_out    = 1'b1;
                    m_req_pc = pc;
                end
            end
            if (grant) begin
                pend_v    = 1'b1;
                pend_cnt  = $urandom_range(1, 3);
                pend_data = ins(pc & 32'hFFFF_FFFC);
            end
            if (e_pcen) pc_next = flush ? ($urandom & 32'h0000_FFFF) : pc + 32'd4;
            else        pc_next = pc;
            @(posedge clk);
            #1;
            pc = pc_next;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ifetch_unit.md
# ifetch_unit

Instruction-fetch stage between the PC register and the IF/ID pipeline register. Each cycle it drives the current PC to instruction memory over a request/grant/response handshake. It tracks the single outstanding read and queues returned instructions with their PCs in a small buffer. It presents them to decode through a valid/ready interface and drives the PC register's enable so the PC advances only when a fetch is accepted or a redirect occurs.

## Interface
Parameters:
- `DEPTH`, 2: instruction buffer entries, power of two, ≥ 2.

Ports:
- `clk`, in, 1: clock; all state updates on the rising edge.
- `rst`, in, 1: reset, synchronous, active-high.
- `pc`, in, 32: current PC from the PC register.
- `pc_en`, out, 1: enable for the PC register.
- `flush`, in, 1: redirect from branch/jump resolution. The PC register loads the target this cycle.
- `imem_req`, out, 1: fetch request.
- `imem_addr`, out, 32: word-aligned fetch address, `{pc[31:2], 2'b00}`.
- `imem_gnt`, in, 1: memory accepts the request this cycle.
- `imem_rvalid`, in, 1: read data valid.
- `imem_rdata`, in, 32: instruction word.
- `id_valid`, out, 1: buffer head is valid.
- `id_instr`, out, 32: head instruction.
- `id_pc`, out, 32: PC of the head instruction.
- `id_ready`, in, 1: decode consumes the head this cycle.

## Operation
- **State.** The unit holds:
  - the buffer, with `count` from 0 to DEPTH;
  - `outstanding` (1 bit);
  - `drop` (1 bit);
  - `req_pc` (32 bits), the PC of the outstanding request.
- **Credit.**
  - `imem_req = !rst && !flush && (!outstanding || imem_rvalid) && (count + outstanding < DEPTH || deq)`.
  - `deq = id_valid && id_ready`.
  - Only one read is in flight at a time.
- **Issue.** When `imem_req && imem_gnt`:
  - set `outstanding`;
  - latch `req_pc <= pc`;
  - assert `pc_en`.
- **PC enable.** `pc_en = flush || (imem_req && imem_gnt)`. `pc_en` is never asserted during `rst`.
- **Response.** When `imem_rvalid && outstanding`:
  - clear `outstanding`, unless a new grant occurs in the same cycle;
  - if `!drop`, enqueue `{req_pc, imem_rdata}`;
  - if `drop`, discard the data and clear `drop`.
- **Unexpected response.** `imem_rvalid` with `!outstanding` is ignored.
- **Dequeue.** On `deq`, pop the head. Enqueue and dequeue in the same cycle keep `count` unchanged.
- **Flush.**
  - Buffer is emptied (`count <= 0`) and no request is issued.
  - If `outstanding && !imem_rvalid`, set `drop` so the late response is discarded.
  - If `imem_rvalid` arrives in the flush cycle, that data is discarded and `outstanding` is cleared.
  - A `deq` in the flush cycle is honoured: the consumer saw the head.
- **Overflow.** The credit rule makes overflow impossible. A full buffer with `!deq` holds `imem_req` low and the PC stalls.
- **Reset.** Registered outputs and state clear:
  - `id_valid=0`, `id_instr=0`, `id_pc=0`;
  - `outstanding=0`, `drop=0`, `count=0`.
  - `imem_req=0` and `pc_en=0` during reset.
  - Reset mid-transaction abandons the in-flight read. A response arriving after reset is ignored because `outstanding=0`.

## Timing
- `imem_req`, `imem_addr` and `pc_en` are combinational from the current state and `pc`. Every other output is registered.
- Response is accepted no earlier than the cycle after its grant.
- Latency from grant to `id_valid` is at least 2 cycles: grant in cycle N, rvalid in N+1, `id_valid` in N+2. There is no bypass from `imem_rdata` to `id_instr`.
- **Sustained throughput** is one instruction per cycle when the memory answers in 1 cycle, `imem_gnt` is held high and `id_ready=1`. This requires rvalid and the next grant in the same cycle.
- `flush` takes effect in the same cycle: no request, and `pc_en=1`. The first post-flush request is issued in the next cycle at the new `pc`.

## Structure
- **Shared package `mips_pkg`:**
  - `RESET_PC = 32'h0000_3000`;
  - `INSTR_W = 32`;
  - `NOP_INSTR = 32'h0000_0000`.
- **Sub-module `ifetch_fifo`:**
  - synchronous FIFO, width 64 (`{pc, instr}`), depth DEPTH;
  - inputs `push`, `pop`, `clear`; outputs `count`, `empty`, `full`;
  - `clear` has priority over `push` and `pop`.
- The top level holds the outstanding/drop tracking and the credit logic.

## Test plan
- **Reset:** hold `rst` 2 cycles with `imem_rvalid=1` → `imem_req=0`, `pc_en=0`, `id_valid=0`, buffer empty after release.
- **Streaming:** `pc` 0x3000, 0x3004, 0x3008, …; 1-cycle memory; `id_ready=1` → `id_pc` 0x3000, 0x3004, 0x3008 on consecutive cycles starting 2 cycles after the first grant; `pc_en=1` every cycle.
- **Backpressure:** `id_ready=0`, DEPTH=2 → exactly 2 grants, then `imem_req=0` and `pc_en=0`. Raising `id_ready` resumes fetch one entry per pop with no duplicated or lost PC.
- **Slow memory:** rvalid 3 cycles after grant → no second request while outstanding; instruction appears with the correct `req_pc`.
- **Flush with in-flight read:** grant at 0x3008, `flush` the next cycle with rvalid 2 cycles later → response dropped; buffer empty; `pc_en=1` in the flush cycle; next fetch uses the target (e.g. 0x3100) and yields `id_pc=0x3100`.
- **Flush coinciding with rvalid and deq:** → head consumed once, returning data discarded, `count=0`, `outstanding=0`.
